nonce_result_collector: RTL and testbench
=========================================

Name: nonce_result_collector

Overview:
Collects winning nonces from NUM_CH parallel mining cores into one result stream. It is the parametrised successor of the three-way fixed-priority output selector.
- Arbitrates among cores that report finished, in round-robin or fixed-priority order.
- Acknowledges each captured core, so no result is lost or duplicated.
- Buffers results in a small FIFO with a valid/ready output handshake.
- Optionally halts all miners once the first nonce is found.

Parameters:
NUM_CH, 3, number of mining cores (>=2)
NONCE_W, 32, nonce width in bits
FIFO_DEPTH, 4, result buffer entries (power of two, >=2)
RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority with lowest index winning
HALT_ON_FIRST, 1, 1 = assert halt_miners after the first capture

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
ch_finished  in  NUM_CH  per-core result request; held high until that core's ch_ack is seen
ch_nonce  in  NUM_CH*NONCE_W  per-core nonce; core i occupies bits [i*NONCE_W +: NONCE_W]
ch_ack  out  NUM_CH  registered one-cycle pulse to the captured core
clear  in  1  synchronous flush/restart for a new job
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts the head entry
out_nonce  out  NONCE_W  head nonce; 0 when empty
out_ch  out  CH_W  head source core index, CH_W = max(1, clog2(NUM_CH)); 0 when empty
found  out  1  sticky: at least one result captured since reset or clear
halt_miners  out  1  stop request to all cores
stall_seen  out  1  sticky: a request was blocked because the FIFO was full

Behaviour:
- Reset (async, reset==0): FIFO empty, RR pointer = NUM_CH-1, and every output is 0 (ch_ack, out_valid, out_nonce, out_ch, found, halt_miners, stall_seen).
- Eligibility: eligible[i] = ch_finished[i] & ~ch_ack[i]. A core acked this cycle cannot win again. Cores must drop finished in the cycle they see ack.
- Grant: at most one grant per cycle, given only if some core is eligible and the FIFO can accept an entry.
- Grant order, RR_MODE=1: search starts at pointer+1 and wraps. The pointer moves to the granted index.
- Grant order, RR_MODE=0: the lowest eligible index wins. The pointer is unused.
- FIFO can accept when: not full, or full with a pop in the same cycle.
- Capture: on a grant, {index, nonce} is written at the edge, ch_ack[index] pulses during the next cycle, and out_valid is high in that same next cycle if the FIFO was empty. Latency from finished sampled to out_valid is 1 cycle.
- Pop: occurs when out_valid & out_ready. Push and pop in the same cycle are both performed and the count is unchanged.
- out_valid & ~out_ready: out_nonce and out_ch must stay stable.
- Full: eligible requests wait with no ack, and stall_seen is set. Requests are never dropped.
- found: set at the edge of the first capture.
- halt_miners: equals found when HALT_ON_FIRST=1, otherwise constant 0. Already-pending requests are still captured after halt.
- clear: has priority over everything. At the edge it empties the FIFO, clears found, halt_miners and stall_seen, and sets the pointer to NUM_CH-1. No grant or ack occurs in that cycle; ch_ack goes to 0 at the same edge.
- Reset mid-operation: all state is discarded immediately, asynchronously.
- Pointers: FIFO read/write pointers are clog2(FIFO_DEPTH)+1 bits. Full and empty come from comparing the MSB and the index bits.

Decomposition:
- Shared package: clog2 function, CH_W derivation, FIFO entry layout constant (CH_W+NONCE_W).
- One sub-module, rr_arbiter: eligible vector, enable and mode in; one-hot grant, encoded index and next pointer out. It is purely combinational plus the pointer register.
- FIFO storage and control stay inline.

Test Plan:
1. Reset, then ch_finished=3'b010 with nonce1=32'hDEADBEEF, out_ready=1. Required: ch_ack=3'b010 next cycle, out_valid=1 with out_nonce=DEADBEEF and out_ch=1, found=1, halt_miners=1.
2. RR_MODE=1, all three cores request continuously and re-request after ack. Required: grants go 0,1,2,0,1,2 and each ack is exactly one cycle.
3. RR_MODE=0, cores 2 and 1 request together. Required: core 1 is captured first and core 2 in the next eligible cycle.
4. out_ready=0, five distinct requests. Required: four entries buffered, the fifth core waits unacked with stall_seen=1. Then out_ready=1: pops come out in capture order and the fifth entry is captured on the first pop cycle.
5. FIFO full, a pop and a new request in the same cycle. Required: count stays 4 and the new nonce is the last entry out.
6. Entries pending, clear=1 together with a request. Required: next cycle out_valid=0, found=0, halt_miners=0, no ack. Async reset mid-burst: all outputs are 0 immediately.

Source files
------------

// File: rtl/nonce_result_collector_pkg.sv
// Shared helpers for the nonce result collector: width derivation and arbitration mode.
package nonce_result_collector_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   // ceil(log2(n)), 0 for n <= 1
   function automatic int clog2_f(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v * 2) r++;
      return r;
   endfunction

   // core index width, at least one bit
   function automatic int ch_w_f(input int num_ch);
      return (clog2_f(num_ch) < 1) ? 1 : clog2_f(num_ch);
   endfunction

   // FIFO entry layout: {core index, nonce}
   function automatic int entry_w_f(input int num_ch, input int nonce_w);
      return ch_w_f(num_ch) + nonce_w;
   endfunction

endpackage

// File: rtl/nonce_result_collector_rr_arbiter.sv
// One-of-N arbiter: round-robin from pointer+1, or fixed lowest-index priority.
module nonce_result_collector_rr_arbiter
   import nonce_result_collector_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int CH_W   = ch_w_f(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [NUM_CH-1:0] eligible,
   input  logic              en,
   input  arb_mode_e         mode,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx,
   output logic [CH_W-1:0]   ptr_next
);

   logic [CH_W-1:0] ptr_q, ptr_d;
   logic [CH_W-1:0] idx_c;
   logic            hit;

   // search position k steps after the last winner; one wrap is enough
   function automatic int slot(input int base, input int k);
      int s;
      s = base + 1 + k;
      if (s >= NUM_CH) s = s - NUM_CH;
      return s;
   endfunction

   // pick first eligible core in search order, advance pointer to it
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      hit       = 1'b0;
      idx_c     = '0;
      ptr_d     = ptr_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (mode == ARB_RR) idx_c = CH_W'(slot(int'(ptr_q), k));
         else                idx_c = CH_W'(k);
         if (en && !hit && eligible[idx_c]) begin
            hit          = 1'b1;
            grant[idx_c] = 1'b1;
            grant_idx    = idx_c;
         end
      end
      if (hit && mode == ARB_RR) ptr_d = grant_idx;
      if (clear) ptr_d = CH_W'(NUM_CH - 1);
      ptr_next = ptr_d;
   end

   // pointer register, restarts so that core 0 is searched first
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr_q <= CH_W'(NUM_CH - 1);
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/nonce_result_collector.sv
// Collects winning nonces from NUM_CH mining cores into one buffered valid/ready stream.
module nonce_result_collector
   import nonce_result_collector_pkg::*;
#(
   parameter  int NUM_CH        = 3,
   parameter  int NONCE_W       = 32,
   parameter  int FIFO_DEPTH    = 4,
   parameter  int RR_MODE       = 1,
   parameter  int HALT_ON_FIRST = 1,
   localparam int CH_W          = ch_w_f(NUM_CH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         ch_finished,
   input  logic [NUM_CH*NONCE_W-1:0] ch_nonce,
   output logic [NUM_CH-1:0]         ch_ack,
   input  logic                      clear,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NONCE_W-1:0]        out_nonce,
   output logic [CH_W-1:0]           out_ch,
   output logic                      found,
   output logic                      halt_miners,
   output logic                      stall_seen
);

   localparam int AW = clog2_f(FIFO_DEPTH);
   localparam int EW = entry_w_f(NUM_CH, NONCE_W);

   logic [EW-1:0]     mem_q [FIFO_DEPTH];
   logic [EW-1:0]     mem_d [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic              found_q, found_d, stall_q, stall_d;

   logic              empty, full, pop, push, can_accept;
   logic [NUM_CH-1:0] eligible, grant;
   logic [CH_W-1:0]   grant_idx, rr_ptr_nxt;
   logic [NONCE_W-1:0] sel_nonce;
   logic [EW-1:0]     head;

   // extra pointer MSB distinguishes full from empty when index bits match
   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = !empty && out_ready;
   assign can_accept = !full || pop;
   // a core still seeing its ack is on its way down and must not win twice
   assign eligible   = ch_finished & ~ack_q;
   assign push       = |grant;

   nonce_result_collector_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .eligible  (eligible),
      .en        (can_accept && !clear),
      .mode      ((RR_MODE != 0) ? ARB_RR : ARB_FIXED),
      .grant     (grant),
      .grant_idx (grant_idx),
      .ptr_next  (rr_ptr_nxt)
   );

   // mux the granted core's nonce
   always_comb begin
      sel_nonce = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (grant[i]) sel_nonce = ch_nonce[i*NONCE_W +: NONCE_W];
   end

   // FIFO, ack and sticky-flag next state; clear overrides everything
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ack_d    = grant;
      found_d  = found_q;
      stall_d  = stall_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = {grant_idx, sel_nonce};
         wr_ptr_d = wr_ptr_q + 1'b1;
         found_d  = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (|eligible && !can_accept) stall_d = 1'b1;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ack_d    = '0;
         found_d  = 1'b0;
         stall_d  = 1'b0;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ack_q    <= '0;
         found_q  <= 1'b0;
         stall_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ack_q    <= ack_d;
         found_q  <= found_d;
         stall_q  <= stall_d;
      end
   end

   assign head        = mem_q[rd_ptr_q[AW-1:0]];
   assign out_valid   = !empty;
   assign out_nonce   = empty ? '0 : head[NONCE_W-1:0];
   assign out_ch      = empty ? '0 : head[EW-1:NONCE_W];
   assign ch_ack      = ack_q;
   assign found       = found_q;
   assign stall_seen  = stall_q;
   assign halt_miners = (HALT_ON_FIRST != 0) ? found_q : 1'b0;

   // round-robin pointer always lands on the core just captured
   rr_ptr_tracks_grant: assert property (@(posedge clk) disable iff (!reset)
      ((RR_MODE != 0) && push && !clear) |-> (rr_ptr_nxt == grant_idx));

endmodule

// File: tb/tb_nonce_result_collector.sv
// Directed bench for nonce_result_collector: one round-robin and one fixed-priority instance.
module tb_nonce_result_collector;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  fin, ack, fin_fp, ack_fp;
   logic [95:0] nonce, nonce_fp;
   logic        clear, clear_fp;
   logic        out_valid, out_ready, found, halt, stall;
   logic        out_valid_fp, out_ready_fp, found_fp, halt_fp, stall_fp;
   logic [31:0] out_nonce, out_nonce_fp;
   logic [1:0]  out_ch, out_ch_fp;

   int checks = 0;
   int fails  = 0;

   nonce_result_collector #(.NUM_CH(3), .NONCE_W(32), .FIFO_DEPTH(4), .RR_MODE(1), .HALT_ON_FIRST(1)) dut (
      .clk(clk), .reset(rst_n), .ch_finished(fin), .ch_nonce(nonce), .ch_ack(ack),
      .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
      .out_ch(out_ch), .found(found), .halt_miners(halt), .stall_seen(stall)
   );

   nonce_result_collector #(.NUM_CH(3), .NONCE_W(32), .FIFO_DEPTH(4), .RR_MODE(0), .HALT_ON_FIRST(1)) dut_fp (
      .clk(clk), .reset(rst_n), .ch_finished(fin_fp), .ch_nonce(nonce_fp), .ch_ack(ack_fp),
      .clear(clear_fp), .out_valid(out_valid_fp), .out_ready(out_ready_fp), .out_nonce(out_nonce_fp),
      .out_ch(out_ch_fp), .found(found_fp), .halt_miners(halt_fp), .stall_seen(stall_fp)
   );

   task automatic do_clear;
      fin = '0; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; fin = '0; nonce = '0; clear = 1'b0; out_ready = 1'b0;
      fin_fp = '0; nonce_fp = '0; clear_fp = 1'b0; out_ready_fp = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ack, out_valid, out_nonce, out_ch, found, halt, stall} !== '0) begin
         $display("FAIL reset_outputs got ack=%b v=%b n=%h ch=%0d f=%b h=%b s=%b exp all 0",
                  ack, out_valid, out_nonce, out_ch, found, halt, stall); fails++;
      end
      checks++;
      if ({ack_fp, out_valid_fp, found_fp, halt_fp} !== '0) begin
         $display("FAIL reset_fp got ack=%b v=%b f=%b h=%b exp 0", ack_fp, out_valid_fp, found_fp, halt_fp); fails++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({ack, out_valid, found, stall} !== '0) begin
         $display("FAIL post_reset_idle got ack=%b v=%b f=%b s=%b exp 0", ack, out_valid, found, stall); fails++;
      end
   endtask

   task automatic test_basic;
      fin = 3'b010; nonce[63:32] = 32'hDEADBEEF; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ack !== 3'b010) begin $display("FAIL basic_ack got=%b exp=010", ack); fails++; end
      checks++;
      if (out_valid !== 1'b1 || out_nonce !== 32'hDEADBEEF || out_ch !== 2'd1) begin
         $display("FAIL basic_head got v=%b n=%h ch=%0d exp v=1 n=deadbeef ch=1", out_valid, out_nonce, out_ch); fails++;
      end
      checks++;
      if (found !== 1'b1 || halt !== 1'b1) begin
         $display("FAIL basic_found got f=%b h=%b exp 1 1", found, halt); fails++;
      end
      fin = '0;
      @(negedge clk);
      checks++;
      if (ack !== 3'b000 || out_valid !== 1'b0) begin
         $display("FAIL basic_drain got ack=%b v=%b exp 000 0", ack, out_valid); fails++;
      end
   endtask

   task automatic test_rr_rotation;
      int e;
      do_clear();
      for (int i = 0; i < 3; i++) nonce[i*32 +: 32] = 32'hC0 + i;
      out_ready = 1'b1; fin = 3'b111;
      for (int s = 0; s < 6; s++) begin
         @(negedge clk);
         e = s % 3;
         checks++;
         if (ack !== 3'(1 << e)) begin $display("FAIL rr_ack step%0d got=%b exp core %0d", s, ack, e); fails++; end
         checks++;
         if (out_valid !== 1'b1 || out_ch !== 2'(e) || out_nonce !== 32'hC0 + e) begin
            $display("FAIL rr_head step%0d got v=%b ch=%0d n=%h exp ch=%0d", s, out_valid, out_ch, out_nonce, e); fails++;
         end
         fin = ~ack;
      end
      fin = '0;
      @(negedge clk);
      checks++;
      if (ack !== 3'b000 || out_valid !== 1'b0) begin
         $display("FAIL rr_end got ack=%b v=%b exp 000 0", ack, out_valid); fails++;
      end
   endtask

   task automatic test_fixed_priority;
      for (int i = 0; i < 3; i++) nonce_fp[i*32 +: 32] = 32'hF0 + i;
      out_ready_fp = 1'b1; fin_fp = 3'b110;
      @(negedge clk);
      checks++;
      if (ack_fp !== 3'b010 || out_ch_fp !== 2'd1) begin
         $display("FAIL fp_first got ack=%b ch=%0d exp 010 1", ack_fp, out_ch_fp); fails++;
      end
      fin_fp = 3'b100;
      @(negedge clk);
      checks++;
      if (ack_fp !== 3'b100 || out_ch_fp !== 2'd2 || out_nonce_fp !== 32'hF2) begin
         $display("FAIL fp_second got ack=%b ch=%0d n=%h exp 100 2 f2", ack_fp, out_ch_fp, out_nonce_fp); fails++;
      end
      fin_fp = 3'b011;
      @(negedge clk);
      checks++;
      if (ack_fp !== 3'b001) begin $display("FAIL fp_lowest got=%b exp=001", ack_fp); fails++; end
      fin_fp = 3'b010;
      @(negedge clk);
      checks++;
      if (ack_fp !== 3'b010) begin $display("FAIL fp_last got=%b exp=010", ack_fp); fails++; end
      fin_fp = '0;
      @(negedge clk);
      checks++;
      if (ack_fp !== 3'b000 || out_valid_fp !== 1'b0) begin
         $display("FAIL fp_end got ack=%b v=%b exp 000 0", ack_fp, out_valid_fp); fails++;
      end
   endtask

   task automatic test_full_stall;
      logic [31:0] exp_n [3];
      logic [1:0]  exp_c [3];
      exp_n = '{32'hA2, 32'hA3, 32'hA4};
      exp_c = '{2'd2, 2'd0, 2'd1};
      do_clear();
      out_ready = 1'b0;
      nonce[31:0] = 32'hA0; nonce[63:32] = 32'hA1; nonce[95:64] = 32'hA2;
      fin = 3'b111;
      @(negedge clk);
      checks++; if (ack !== 3'b001) begin $display("FAIL full_c1 got=%b exp=001", ack); fails++; end
      fin = 3'b110; nonce[31:0] = 32'hA3;
      @(negedge clk);
      checks++; if (ack !== 3'b010) begin $display("FAIL full_c2 got=%b exp=010", ack); fails++; end
      fin = 3'b101; nonce[63:32] = 32'hA4;
      @(negedge clk);
      checks++; if (ack !== 3'b100) begin $display("FAIL full_c3 got=%b exp=100", ack); fails++; end
      fin = 3'b011;
      @(negedge clk);
      checks++;
      if (ack !== 3'b001 || stall !== 1'b0) begin $display("FAIL full_c4 got ack=%b s=%b exp 001 0", ack, stall); fails++; end
      fin = 3'b010;
      @(negedge clk);
      checks++;
      if (ack !== 3'b000 || stall !== 1'b1) begin $display("FAIL full_stall got ack=%b s=%b exp 000 1", ack, stall); fails++; end
      checks++;
      if (out_valid !== 1'b1 || out_nonce !== 32'hA0 || out_ch !== 2'd0) begin
         $display("FAIL full_head got v=%b n=%h ch=%0d exp 1 a0 0", out_valid, out_nonce, out_ch); fails++;
      end
      @(negedge clk);
      checks++;
      if (ack !== 3'b000 || out_nonce !== 32'hA0 || out_ch !== 2'd0) begin
         $display("FAIL full_hold got ack=%b n=%h ch=%0d exp 000 a0 0", ack, out_nonce, out_ch); fails++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ack !== 3'b010 || out_nonce !== 32'hA1 || out_ch !== 2'd1) begin
         $display("FAIL full_pop_capture got ack=%b n=%h ch=%0d exp 010 a1 1", ack, out_nonce, out_ch); fails++;
      end
      fin = '0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_nonce !== exp_n[j] || out_ch !== exp_c[j]) begin
            $display("FAIL full_order%0d got v=%b n=%h ch=%0d exp n=%h ch=%0d", j, out_valid, out_nonce, out_ch, exp_n[j], exp_c[j]); fails++;
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin $display("FAIL full_empty got v=%b exp 0", out_valid); fails++; end
   endtask

   task automatic test_clear;
      out_ready = 1'b0; fin = 3'b001; nonce[31:0] = 32'hD0;
      @(negedge clk);
      checks++;
      if (ack !== 3'b001 || out_valid !== 1'b1) begin $display("FAIL clr_setup got ack=%b v=%b exp 001 1", ack, out_valid); fails++; end
      fin = 3'b010; nonce[63:32] = 32'hD1; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checks++;
      if ({ack, out_valid, found, halt, stall} !== '0) begin
         $display("FAIL clr_flush got ack=%b v=%b f=%b h=%b s=%b exp 0", ack, out_valid, found, halt, stall); fails++;
      end
      @(negedge clk);
      checks++;
      if (ack !== 3'b010 || out_valid !== 1'b1 || out_ch !== 2'd1 || out_nonce !== 32'hD1 || found !== 1'b1) begin
         $display("FAIL clr_after got ack=%b v=%b ch=%0d n=%h f=%b exp 010 1 1 d1 1", ack, out_valid, out_ch, out_nonce, found); fails++;
      end
      fin = 3'b101;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({ack, out_valid, out_nonce, out_ch, found, halt, stall} !== '0) begin
         $display("FAIL async_reset got ack=%b v=%b n=%h ch=%0d f=%b h=%b s=%b exp 0",
                  ack, out_valid, out_nonce, out_ch, found, halt, stall); fails++;
      end
      @(negedge clk);
      fin = '0; rst_n = 1'b1;
   endtask

   task automatic test_back_to_back;
      do_clear();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         fin = 3'(1 << (k % 3));
         nonce[(k % 3)*32 +: 32] = 32'hB0 + k;
         @(negedge clk);
         checks++;
         if (ack !== fin) begin $display("FAIL b2b_fill%0d got=%b exp=%b", k, ack, fin); fails++; end
         fin = '0;
         @(negedge clk);
      end
      out_ready = 1'b1; fin = 3'b100; nonce[95:64] = 32'hB4;
      @(negedge clk);
      checks++;
      if (ack !== 3'b100 || out_nonce !== 32'hB1) begin
         $display("FAIL b2b_pushpop got ack=%b n=%h exp 100 b1", ack, out_nonce); fails++;
      end
      fin = '0;
      for (int j = 2; j < 5; j++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_nonce !== 32'hB0 + j) begin
            $display("FAIL b2b_drain%0d got v=%b n=%h exp %h", j, out_valid, out_nonce, 32'hB0 + j); fails++;
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin $display("FAIL b2b_count got v=%b exp 0", out_valid); fails++; end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rr_rotation();
      test_fixed_priority();
      test_full_stall();
      test_clear();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
